// File: rtl/riscv_regfile_pkg.sv
// Shared defaults and helpers for the multi-port RISC-V register file.
package riscv_regfile_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int NREGS_DEF    = 32;
  localparam int WB_DELAY_DEF = 3;

  // Register address width for a file of n registers.
  function automatic int addr_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/riscv_wb_delay.sv
// Tagged write-address delay line: carries decode-time destination addresses
// to the write-back stage, honouring stall (hold) and flush (invalidate).
module riscv_wb_delay #(
  parameter int AW       = 5,
  parameter int WB_DELAY = 3
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             stall_i,
  input  logic                             flush_i,
  input  logic [AW-1:0]                    addr_i,
  output logic                             commit_valid_o,
  output logic [AW-1:0]                    commit_addr_o,
  output logic [WB_DELAY-1:0]              stage_valid_o,
  output logic [WB_DELAY-1:0][AW-1:0]      stage_addr_o
);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
  } wb_tag_t;

  wb_tag_t [WB_DELAY-1:0] stage_q;
  wb_tag_t [WB_DELAY-1:0] stage_d;

  // Next stage contents: shift when not stalled; flush clears every tag,
  // including the one entering this edge, and overrides stall.
  always_comb begin
    stage_d = stage_q;
    if (!stall_i) begin
      stage_d[0] = {1'b1, addr_i};
      for (int k = 1; k < WB_DELAY; k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end
    if (flush_i) begin
      for (int k = 0; k < WB_DELAY; k++) begin
        stage_d[k].valid = 1'b0;
      end
    end
  end

  // Stage registers; reset drops every in-flight tag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign commit_valid_o = stage_q[WB_DELAY-1].valid;
  assign commit_addr_o  = stage_q[WB_DELAY-1].addr;

  genvar gi;
  generate
    for (gi = 0; gi < WB_DELAY; gi++) begin : g_stage_out
      assign stage_valid_o[gi] = stage_q[gi].valid;
      assign stage_addr_o[gi]  = stage_q[gi].addr;
    end
  endgenerate

endmodule

// File: rtl/riscv_regfile_mp.sv
// Multi-read-port RISC-V register file with x0 hardwired to zero, a delayed
// write address aligned to write-back, pending-write flags and optional bypass.
module riscv_regfile_mp
  import riscv_regfile_pkg::*;
#(
  parameter int  XLEN     = XLEN_DEF,
  parameter int  NREGS    = NREGS_DEF,
  parameter int  NRD      = 2,
  parameter int  WB_DELAY = WB_DELAY_DEF,
  parameter bit  BYPASS   = 1'b1,
  localparam int AW       = addr_w(NREGS)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      RegWEn_i,
  input  logic [AW-1:0]             AddrD_i,
  input  logic [XLEN-1:0]           DataD_i,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic [NRD-1:0][AW-1:0]    Addr_i,
  output logic [NRD-1:0][XLEN-1:0]  Data_o,
  output logic [NREGS-1:0]          pend_o
);

  logic            commit_valid;
  logic [AW-1:0]   commit_addr;
  logic            commit_we;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  genvar gi;
  generate
    if (WB_DELAY > 0) begin : g_delay
      logic [WB_DELAY-1:0]         stage_valid;
      logic [WB_DELAY-1:0][AW-1:0] stage_addr;

      riscv_wb_delay #(
        .AW       (AW),
        .WB_DELAY (WB_DELAY)
      ) u_wb_delay (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .addr_i         (AddrD_i),
        .commit_valid_o (commit_valid),
        .commit_addr_o  (commit_addr),
        .stage_valid_o  (stage_valid),
        .stage_addr_o   (stage_addr)
      );

      // Pending flags: OR-decode of every valid in-flight address; x0 masked.
      always_comb begin
        pend_o = '0;
        for (int k = 0; k < WB_DELAY; k++) begin
          if (stage_valid[k]) begin
            pend_o[stage_addr[k]] = 1'b1;
          end
        end
        pend_o[0] = 1'b0;
      end
    end else begin : g_no_delay
      // Without a delay line the decode address commits directly and nothing
      // is ever in flight, so flush has nothing to act on.
      logic unused_flush;
      assign unused_flush = flush_i;
      assign commit_valid = 1'b1;
      assign commit_addr  = AddrD_i;
      assign pend_o       = '0;
    end
  endgenerate

  assign commit_we = !rst_i && !stall_i && RegWEn_i && commit_valid &&
                     (commit_addr != '0);

  // Next array contents: at most one register updated per cycle.
  always_comb begin
    regs_d = regs_q;
    if (commit_we) begin
      regs_d[commit_addr] = DataD_i;
    end
  end

  // Register array; reset clears every entry and blocks the commit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic byp_hit;
      assign byp_hit    = BYPASS && commit_we && (commit_addr == Addr_i[gi]);
      assign Data_o[gi] = (Addr_i[gi] == '0) ? '0 :
                          byp_hit            ? DataD_i :
                                               regs_q[Addr_i[gi]];
    end
  endgenerate

endmodule

// File: tb/tb_riscv_regfile_mp.sv
// Directed bench for riscv_regfile_mp: a default instance (NRD=2, WB_DELAY=3,
// BYPASS=1) and a second instance with NRD=3, WB_DELAY=0, BYPASS=0.
module tb_riscv_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic             rst_a, we_a, stall_a, flush_a;
  logic [4:0]       addrd_a;
  logic [31:0]      datad_a;
  logic [1:0][4:0]  raddr_a;
  logic [1:0][31:0] rdata_a;
  logic [31:0]      pend_a;

  // No-delay, no-bypass, three read ports
  logic             rst_b, we_b, stall_b, flush_b;
  logic [4:0]       addrd_b;
  logic [31:0]      datad_b;
  logic [2:0][4:0]  raddr_b;
  logic [2:0][31:0] rdata_b;
  logic [31:0]      pend_b;

  int checks = 0;
  int errors = 0;

  riscv_regfile_mp dut_a (
    .clk_i    (clk),
    .rst_i    (rst_a),
    .RegWEn_i (we_a),
    .AddrD_i  (addrd_a),
    .DataD_i  (datad_a),
    .stall_i  (stall_a),
    .flush_i  (flush_a),
    .Addr_i   (raddr_a),
    .Data_o   (rdata_a),
    .pend_o   (pend_a)
  );

  riscv_regfile_mp #(
    .NRD      (3),
    .WB_DELAY (0),
    .BYPASS   (1'b0)
  ) dut_b (
    .clk_i    (clk),
    .rst_i    (rst_b),
    .RegWEn_i (we_b),
    .AddrD_i  (addrd_b),
    .DataD_i  (datad_b),
    .stall_i  (stall_b),
    .flush_i  (flush_b),
    .Addr_i   (raddr_b),
    .Data_o   (rdata_b),
    .pend_o   (pend_b)
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %0d %s observed=%0h expected=%0h", checks, tag, obs, exp);
  endtask

  initial begin
    rst_a = 1'b1; we_a = 1'b0; stall_a = 1'b0; flush_a = 1'b0;
    addrd_a = '0; datad_a = '0; raddr_a = '0;
    rst_b = 1'b1; we_b = 1'b0; stall_b = 1'b0; flush_b = 1'b0;
    addrd_b = '0; datad_b = '0; raddr_b = '0;
    repeat (2) @(negedge clk);

    // 1: reset state
    rst_a = 1'b0; rst_b = 1'b0;
    raddr_a = {5'd1, 5'd0}; #1;
    chk("t1_x0_p0", rdata_a[0], 0);
    chk("t1_x1_p1", rdata_a[1], 0);
    raddr_a = {5'd31, 5'd31}; #1;
    chk("t1_x31", rdata_a, 0);
    chk("t1_pend", pend_a, 0);
    chk("t1_b_rd", rdata_b, 0);

    // 2: basic write with bypass, WB_DELAY=3
    @(negedge clk); addrd_a = 5'd2; raddr_a = {5'd2, 5'd2}; #1;
    chk("t2_pend_c0", pend_a, 0);
    @(negedge clk); addrd_a = 5'd0; #1;
    chk("t2_pend_c1", pend_a, 32'h4);
    @(negedge clk); #1;
    chk("t2_pend_c2", pend_a, 32'h4);
    chk("t2_rd_c2", rdata_a[0], 0);
    @(negedge clk); we_a = 1'b1; datad_a = 32'h16; #1;
    chk("t2_byp_p0", rdata_a[0], 32'h16);
    chk("t2_byp_p1", rdata_a[1], 32'h16);
    chk("t2_pend_c3", pend_a, 32'h4);
    @(negedge clk); we_a = 1'b0; datad_a = 0; #1;
    chk("t2_arr_c4", rdata_a[0], 32'h16);
    chk("t2_pend_c4", pend_a, 0);

    // 3: write to x0 discarded
    @(negedge clk); addrd_a = 5'd0; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    @(negedge clk); we_a = 1'b1; datad_a = 32'hFFFF_FFFF; raddr_a = {5'd2, 5'd0}; #1;
    chk("t3_x0_c3", rdata_a[0], 0);
    chk("t3_x2_c3", rdata_a[1], 32'h16);
    @(negedge clk); we_a = 1'b0; raddr_a = {5'd2, 5'd31}; #1;
    chk("t3_x31_c4", rdata_a[0], 0);
    chk("t3_x2_c4", rdata_a[1], 32'h16);
    raddr_a = {5'd0, 5'd0}; #1;
    chk("t3_x0_c4", rdata_a, 0);

    // 4: stall holds the line and suppresses commit (x4 at write-back while stalled)
    @(negedge clk); addrd_a = 5'd4; #1;
    @(negedge clk); addrd_a = 5'd0; #1;
    @(negedge clk); addrd_a = 5'd5; raddr_a = {5'd4, 5'd5}; #1;
    @(negedge clk); addrd_a = 5'd0; stall_a = 1'b1; we_a = 1'b1; datad_a = 32'h77; #1;
    chk("t4_x4_stall_c1", rdata_a[1], 0);
    chk("t4_x5_stall_c1", rdata_a[0], 0);
    chk("t4_pend_c1", pend_a, 32'h30);
    @(negedge clk); #1;
    chk("t4_x4_stall_c2", rdata_a[1], 0);
    chk("t4_pend_c2", pend_a, 32'h30);
    @(negedge clk); stall_a = 1'b0; datad_a = 32'h18; #1;
    chk("t4_x4_byp_c3", rdata_a[1], 32'h18);
    chk("t4_x5_c3", rdata_a[0], 0);
    @(negedge clk); #1;
    chk("t4_x5_c4", rdata_a[0], 0);
    chk("t4_x4_c4", rdata_a[1], 32'h18);
    @(negedge clk); #1;
    chk("t4_x5_byp_c5", rdata_a[0], 32'h18);
    chk("t4_pend_c5", pend_a, 32'h20);
    @(negedge clk); we_a = 1'b0; #1;
    chk("t4_x5_c6", rdata_a[0], 32'h18);
    chk("t4_pend_c6", pend_a, 0);

    // 5: flush kills an in-flight write
    @(negedge clk); addrd_a = 5'd6; raddr_a = {5'd6, 5'd6}; #1;
    @(negedge clk); addrd_a = 5'd0; flush_a = 1'b1; #1;
    chk("t5_pend_c1", pend_a, 32'h40);
    @(negedge clk); flush_a = 1'b0; #1;
    chk("t5_pend_c2", pend_a, 0);
    @(negedge clk); we_a = 1'b1; datad_a = 32'h12; #1;
    chk("t5_x6_c3", rdata_a[0], 0);
    @(negedge clk); we_a = 1'b0; #1;
    chk("t5_x6_c4", rdata_a[0], 0);

    // 5b: flush wins over stall; commit in a flush cycle still completes
    @(negedge clk); addrd_a = 5'd10; #1;
    @(negedge clk); addrd_a = 5'd0; stall_a = 1'b1; flush_a = 1'b1; #1;
    chk("t5b_pend_c1", pend_a, 32'h400);
    @(negedge clk); stall_a = 1'b0; flush_a = 1'b0; #1;
    chk("t5b_pend_c2", pend_a, 0);
    @(negedge clk); addrd_a = 5'd11; raddr_a = {5'd11, 5'd11}; #1;
    @(negedge clk); addrd_a = 5'd0; #1;
    @(negedge clk); #1;
    @(negedge clk); we_a = 1'b1; datad_a = 32'h33; flush_a = 1'b1; #1;
    chk("t5b_x11_byp", rdata_a[0], 32'h33);
    @(negedge clk); we_a = 1'b0; flush_a = 1'b0; #1;
    chk("t5b_x11_arr", rdata_a[1], 32'h33);
    chk("t5b_pend", pend_a, 0);

    // 6: WB_DELAY=0, BYPASS=0, three ports; reset mid-sequence
    @(negedge clk); addrd_b = 5'd7; we_b = 1'b1; datad_b = 32'hA5;
    raddr_b = {5'd7, 5'd7, 5'd7}; #1;
    chk("t6_old_c0", rdata_b, 0);
    chk("t6_pend_b", pend_b, 0);
    @(negedge clk); we_b = 1'b0; #1;
    chk("t6_new_c1", rdata_b, {3{32'hA5}});
    @(negedge clk); rst_b = 1'b1; we_b = 1'b1; datad_b = 32'h55; #1;
    chk("t6_rst_c2", rdata_b, {3{32'hA5}});
    @(negedge clk); rst_b = 1'b0; we_b = 1'b0; #1;
    chk("t6_cleared_c3", rdata_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
